// File: rtl/demux_1a2.sv
// demux_1a2: buffered 1-to-2 valid/ready demultiplexer with one FIFO per output channel; optional macro DEMUX_1A2_STATS_EN adds push and stall counters
module demux_1a2 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_1A2_STATS_EN
  ,
  output logic [15:0]      stat0,
  output logic [15:0]      stat1,
  output logic [15:0]      stall_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [2][DEPTH];
  logic [AW-1:0] wptr [2];
  logic [AW-1:0] rptr [2];
  logic [CW-1:0] cnt [2];
  logic [1:0] full, valid, ready, push, pop;
  assign ready = {out1_ready, out0_ready};
  assign in_ready = !full[in_sel];
  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign out0_data = mem[0][rptr[0]];
  assign out1_data = mem[1][rptr[1]];
  // per-channel status and handshake decode; in_ready sees only registered counts
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      full[i] = cnt[i] == CW'(DEPTH);
      valid[i] = cnt[i] != '0;
      push[i] = in_valid && !full[i] && (in_sel == 1'(i));
      pop[i] = valid[i] && ready[i];
    end
  end
  // pointer and occupancy update; simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < 2; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i] <= '0;
      end
    else
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + 1'b1;
        if (pop[i]) rptr[i] <= rptr[i] + 1'b1;
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
      end
  // storage array is left unreset; stale entries are masked by the counts
  always_ff @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (push[i]) mem[i][wptr[i]] <= in_data;
`ifdef DEMUX_1A2_STATS_EN
  // saturating counters for accepted pushes per channel and stalled input cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat0 <= '0;
      stat1 <= '0;
      stall_cnt <= '0;
    end else begin
      if (push[0] && stat0 != '1) stat0 <= stat0 + 1'b1;
      if (push[1] && stat1 != '1) stat1 <= stat1 + 1'b1;
      if (in_valid && !in_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
`endif
endmodule

// File: doc/demux_1a2.md
# demux_1a2

Buffered 1-to-2 demultiplexer for the datapath. It routes a 32-bit word from a single valid/ready source to one of two valid/ready destinations, chosen per word by a select bit. Each destination has its own small FIFO, so a stalled consumer does not block words headed to the other consumer once they are queued. It sits wherever one producer, such as the ALU result or a writeback bus, feeds two consumers, and is the distributing counterpart of the 2:1 operand/PC multiplexers.

## Interface
Parameters:
- `WIDTH`, default 32: data width in bits.
- `DEPTH`, default 2: entries per output FIFO. Must be a power of 2, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  source presents a word.
- `in_ready`  out  1  block accepts the word this cycle.
- `in_data`  in  WIDTH  word to route.
- `in_sel`  in  1  destination: 0 routes to channel 0, 1 routes to channel 1. Sampled with `in_data`.
- `out0_valid`, `out1_valid`  out  1  channel head word is valid.
- `out0_ready`, `out1_ready`  in  1  consumer takes the head word.
- `out0_data`, `out1_data`  out  WIDTH  channel head word.

## Operation
- Each channel has an independent FIFO: a DEPTH-entry register array, a write pointer, a read pointer (log2(DEPTH) bits, wrapping modulo DEPTH) and an occupancy count (log2(DEPTH)+1 bits).
- Input accept: an accept occurs when `in_valid && in_ready`. The word is written into FIFO[`in_sel`], that channel's write pointer advances, and its count increments.
- `in_ready` is combinational: `in_ready = !full[in_sel]`.
  - It depends only on the selected channel's registered count.
  - There is no combinational path from `out*_ready` to `in_ready`.
- Output pop: a pop occurs when `outN_valid && outN_ready`. The read pointer advances and the count decrements.
- `outN_valid = (countN != 0)`.
- `outN_data` is the entry at the read pointer. When `outN_valid` = 0 its value is don't-care.
- Push and pop on the same channel in the same cycle: the count is unchanged and both pointers advance.
- Full channel with a pop this cycle: `in_ready` stays 0 this cycle. The freed slot becomes usable the next cycle.
- Empty channel with a push this cycle: `outN_valid` rises the next cycle. There is no bypass.
- Words on one channel leave in acceptance order. There is no ordering guarantee between channels.
- When `in_valid` = 0, `in_sel` and `in_data` are ignored.
- Reset (asynchronous assert, any time including mid-transfer): all pointers and counts go to 0 and all queued words are discarded.
  - Outputs during and after reset: `out0_valid` = `out1_valid` = 0; `in_ready` = 1, with both FIFOs empty.
  - The FIFO data arrays are not reset.
  - Deassertion is expected synchronous to `clk`; the block adds no synchronizer.

## Timing
- Latency from an accepted input to `outN_valid`: 1 cycle.
- Throughput: 1 word per cycle sustained on any mix of channels, provided the target channel is not full.
- Per channel, when the consumer holds `outN_ready` = 1 and the channel is steady-state, the count stays ≤ 1.
- A full channel throttles only the words selected for it. Words for the other channel are accepted in the same cycle.
- No state machine beyond the per-channel FIFO counters.

## Configuration
- Macro: `DEMUX_1A2_STATS_EN`.
- Defined:
  - Adds output `stat0`, 16 bits, counting accepted pushes into channel 0.
  - Adds output `stat1`, 16 bits, counting accepted pushes into channel 1.
  - Adds output `stall_cnt`, 16 bits, counting cycles with `in_valid && !in_ready`.
  - All three counters saturate at 16'hFFFF, reset to 0 on `rst_n`, and update on the same edge as the event.
- Undefined: the ports and counter logic are absent. Routing behaviour is identical in both builds.

## Test plan
1. Reset mid-traffic: load channel 0 with 2 words and channel 1 with 1 word, then pulse `rst_n` low between edges.
   - Required: both valids go 0 immediately and `in_ready` = 1.
   - Required: after release, the next accepted word appears alone on its channel.
2. Routing and latency: push 32'hA5A5_0001 with sel 0, then 32'h5A5A_0002 with sel 1, on consecutive cycles with both consumers ready.
   - Required: each word appears on its own channel exactly 1 cycle after its accept, with no word on the other channel.
3. Full channel: `out0_ready` = 0, DEPTH = 2. Push 3 words with sel 0.
   - Required: the third push sees `in_ready` = 0.
   - Then present sel 1 while holding the third word: it is accepted and appears on `out1` the next cycle.
4. Full plus pop same cycle: channel 0 full, assert `out0_ready` for 1 cycle while `in_valid` = 1 with sel 0.
   - Required: `in_ready` = 0 that cycle and 1 the next cycle.
   - Required: pop order matches push order.
5. Wrap-around: 10 words on channel 1 with random `out1_ready` backpressure.
   - Required: output sequence equals input sequence and the count never exceeds 2.
6. With `DEMUX_1A2_STATS_EN`: 5 pushes to channel 0, 3 to channel 1, and 4 stalled cycles.
   - Required: `stat0` = 5, `stat1` = 3, `stall_cnt` = 4.
   - Forcing 70000 stall cycles saturates `stall_cnt` at 16'hFFFF.
